// File: rtl/neo_frame_sequencer.sv
// -----------------------------------------------------------------------------
// neo_frame_sequencer
//
// Purpose:
//   Frame controller for the Nonlinear Energy Operator datapath. A start pulse
//   in IDLE launches one frame: M samples are read from a synchronous sample
//   memory (1-cycle read latency) and psi[n] = x[n]^2 - x[n-1]*x[n+1] is
//   written, exactly, to a result memory in ascending address order. Entries 0
//   and M-1 have no neighbour and are written as 0. A one-cycle done pulse
//   closes the frame.
//
// Handshake:
//   start is sampled only in IDLE; busy is high from the first read cycle up to
//   and including the last write cycle; done pulses once per completed frame.
//   Reads: ren/raddr, rdata valid the cycle after ren. Writes: wen/waddr/wdata,
//   one entry per cycle while wen=1, waddr/wdata hold while wen=0.
//
// Ports:
//   Clk        clock, all state on rising edge
//   reset      asynchronous, active-low reset
//   start      frame request
//   busy       frame in progress
//   done       single-cycle frame-complete pulse
//   ren        sample-memory read enable
//   raddr      sample address [AW-1:0]
//   rdata      signed sample [N-1:0]
//   wen        result-memory write enable
//   waddr      result address [AW-1:0]
//   wdata      signed psi result [2N:0]
//   thresh     (NEO_SPIKE_CNT_EN only) signed spike threshold [2N:0]
//   spike_cnt  (NEO_SPIKE_CNT_EN only) count of written entries > thresh
//
// Configuration:
//   NEO_SPIKE_CNT_EN  when defined, adds thresh/spike_cnt and the spike counter.
// -----------------------------------------------------------------------------
module neo_frame_sequencer #(
   parameter  int N  = 8,
   parameter  int M  = 16,
   localparam int AW = $clog2(M)
) (
   input  logic                Clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                ren,
   output logic [AW-1:0]       raddr,
   input  logic signed [N-1:0] rdata,
   output logic                wen,
   output logic [AW-1:0]       waddr,
   output logic signed [2*N:0] wdata
`ifdef NEO_SPIKE_CNT_EN
   ,
   input  logic signed [2*N:0] thresh,
   output logic [AW:0]         spike_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [AW-1:0] LAST = AW'(M - 1);

   state_t              r_state;
   logic                r_busy;
   logic                r_done;
   logic                r_ren;
   logic [AW-1:0]       r_raddr;
   logic                r_wen;
   logic [AW-1:0]       r_waddr;
   logic signed [2*N:0] r_wdata;

   // Sample pipeline: r_xp = x[n-1], r_xc = x[n]; rdata is x[n+1].
   logic signed [N-1:0] r_xp;
   logic signed [N-1:0] r_xc;
   logic                r_rvalid;   // rdata carries a sample this cycle
   logic [AW-1:0]       r_sidx;     // index of the sample on rdata
   logic                r_tail;     // issue the trailing boundary write

   logic signed [2*N:0] w_xp_e;
   logic signed [2*N:0] w_xc_e;
   logic signed [2*N:0] w_xn_e;
   logic signed [2*N:0] w_psi;

   // Operands widened to 2N+1 bits so the products and difference are exact.
   assign w_xp_e = {{(N+1){r_xp[N-1]}}, r_xp};
   assign w_xc_e = {{(N+1){r_xc[N-1]}}, r_xc};
   assign w_xn_e = {{(N+1){rdata[N-1]}}, rdata};
   assign w_psi  = (w_xc_e * w_xc_e) - (w_xp_e * w_xn_e);

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ren    <= 1'b0;
         r_raddr  <= '0;
         r_wen    <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_xp     <= '0;
         r_xc     <= '0;
         r_rvalid <= 1'b0;
         r_sidx   <= '0;
         r_tail   <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_wen    <= 1'b0;
         r_rvalid <= r_ren;

         // Arrival of sample k completes the neighbourhood of entry k-1,
         // so entry k-1 is written on the next edge.
         if (r_rvalid) begin
            r_xp   <= r_xc;
            r_xc   <= rdata;
            r_sidx <= r_sidx + AW'(1);
            if (r_sidx != '0) begin
               r_wen   <= 1'b1;
               r_waddr <= r_sidx - AW'(1);
               r_wdata <= (r_sidx == AW'(1)) ? '0 : w_psi;
            end
         end

         // Entry M-1 has no right neighbour: written as 0 one cycle after M-2.
         r_tail <= r_rvalid && (r_sidx == LAST);
         if (r_tail) begin
            r_wen   <= 1'b1;
            r_waddr <= LAST;
            r_wdata <= '0;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_READ;
                  r_busy  <= 1'b1;
                  r_ren   <= 1'b1;
                  r_raddr <= '0;
                  r_sidx  <= '0;
                  r_xp    <= '0;
                  r_xc    <= '0;
               end
            end
            S_READ: begin
               if (r_raddr == LAST) begin
                  r_ren   <= 1'b0;
                  r_state <= S_DRAIN;
               end else begin
                  r_raddr <= r_raddr + AW'(1);
               end
            end
            S_DRAIN: begin
               // The final write is on the outputs this cycle.
               if (r_wen && (r_waddr == LAST)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign ren   = r_ren;
   assign raddr = r_raddr;
   assign wen   = r_wen;
   assign waddr = r_waddr;
   assign wdata = r_wdata;

`ifdef NEO_SPIKE_CNT_EN
   logic [AW:0] r_spike_cnt;

   // Counts each written entry strictly above thresh, one cycle after the
   // write; cleared when a frame is accepted, held after done.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         r_spike_cnt <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_spike_cnt <= '0;
      end else if (r_wen && (r_wdata > thresh)) begin
         r_spike_cnt <= r_spike_cnt + (AW+1)'(1);
      end
   end

   assign spike_cnt = r_spike_cnt;
`endif

endmodule

// File: tb/tb_neo_frame_sequencer.sv
module tb_neo_frame_sequencer;

  localparam int N  = 8;
  localparam int M  = 16;
  localparam int AW = 4;
  localparam int QW = AW + 2*N + 1;

  logic                Clk = 1'b0;
  logic                reset;
  logic                start;
  logic                busy;
  logic                done;
  logic                ren;
  logic [AW-1:0]       raddr;
  logic signed [N-1:0] rdata;
  logic                wen;
  logic [AW-1:0]       waddr;
  logic signed [2*N:0] wdata;
`ifdef NEO_SPIKE_CNT_EN
  logic signed [2*N:0] thresh;
  logic [AW:0]         spike_cnt;
`endif

  logic signed [N-1:0] mem [M];
  logic [QW-1:0]       exp_q[$];
  int                  total = 0;
  int                  bad   = 0;
  int                  th    = 0;

  neo_frame_sequencer #(.N(N), .M(M)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ren       (ren),
    .raddr     (raddr),
    .rdata     (rdata),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata)
`ifdef NEO_SPIKE_CNT_EN
    ,
    .thresh    (thresh),
    .spike_cnt (spike_cnt)
`endif
  );

  // clock / reset block
  always #5 Clk = ~Clk;

`ifdef NEO_SPIKE_CNT_EN
  assign thresh = (2*N+1)'(th);
`endif

  // synchronous sample memory, one-cycle read latency
  always @(posedge Clk) begin
    if (ren) rdata <= mem[raddr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference model: push the expected write stream, return spike count
  task automatic build_exp(output int cnt);
    int v;
    int a;
    int b;
    int c;
    cnt = 0;
    for (int n = 0; n < M; n++) begin
      if (n == 0 || n == M-1) begin
        v = 0;
      end else begin
        a = int'(mem[n-1]);
        b = int'(mem[n]);
        c = int'(mem[n+1]);
        v = b*b - a*c;
      end
      if (v > th) cnt++;
      exp_q.push_back({AW'(n), (2*N+1)'(v)});
    end
  endtask

  // one full frame, start accepted in the current cycle (t0)
  task automatic run_frame(input bit keep, input bit retrig);
    int            cnt_exp;
    logic [QW-1:0] e;
    build_exp(cnt_exp);
    start = 1'b1;
    for (int c = 1; c <= M+5; c++) begin
      tick();
      if (c == 1 && !keep) start = 1'b0;
      if (retrig && c == 5) start = 1'b1;
      if (retrig && c == 6) start = 1'b0;
      chk("busy", 64'(busy), 64'(c >= 1 && c <= M+3));
      chk("ren",  64'(ren),  64'(c >= 1 && c <= M));
      if (ren) chk("raddr", 64'(raddr), 64'(c-1));
      chk("wen",  64'(wen),  64'(c >= 4 && c <= M+3));
      chk("done", 64'(done), 64'(c == M+4));
      if (wen) begin
        if (exp_q.size() == 0) begin
          chk("wr_extra", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr_data", 64'({waddr, wdata}), 64'(e));
        end
      end
`ifdef NEO_SPIKE_CNT_EN
      if (c == 1)   chk("spike_clr", 64'(spike_cnt), 64'(0));
      if (c == M+4) chk("spike_cnt", 64'(spike_cnt), 64'(cnt_exp));
`endif
    end
    chk("q_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic set_ramp();
    for (int k = 0; k < M; k++) mem[k] = N'(k);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int k = 0; k < M; k++) mem[k] = '0;
    tick();
    tick();
    // reset state
    chk("rst_busy",  64'(busy),  64'(0));
    chk("rst_done",  64'(done),  64'(0));
    chk("rst_ren",   64'(ren),   64'(0));
    chk("rst_raddr", 64'(raddr), 64'(0));
    chk("rst_wen",   64'(wen),   64'(0));
    chk("rst_waddr", 64'(waddr), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    reset = 1'b1;
    // start low: nothing moves
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_out", 64'({busy, done, ren, wen}), 64'(0));
    end

    // ramp: interior entries are 1, boundaries 0
    set_ramp();
    run_frame(1'b0, 1'b0);

    // extremes
    for (int k = 0; k < M; k++) mem[k] = '0;
    mem[3] = -8'sd128;
    mem[4] = -8'sd128;
    mem[5] = 8'sd127;
    run_frame(1'b0, 1'b0);

    // second start pulse mid-frame is ignored
    set_ramp();
    run_frame(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_refire", 64'({busy, ren, done}), 64'(0));
    end

    // start held high: frames back to back every M+5 cycles
    run_frame(1'b1, 1'b0);
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b0);

    // abort mid-frame with reset
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 8; c++) tick();
    chk("abort_raddr", 64'(raddr), 64'(7));
    reset = 1'b0;
    #1;
    chk("abort_out", 64'({busy, done, ren, raddr, wen, waddr, wdata}), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_nodone", 64'({busy, done}), 64'(0));
    end
    exp_q.delete();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_abort_idle", 64'({busy, done, ren, wen}), 64'(0));
    end
    run_frame(1'b0, 1'b0);

`ifdef NEO_SPIKE_CNT_EN
    set_ramp();
    th = -1;
    run_frame(1'b0, 1'b0);
    th = 0;
    run_frame(1'b0, 1'b0);
    th = 1;
    run_frame(1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
